sass_seq_ctrl: RTL and testbench

- Step-sequencer controller and note arbiter for the SaSS synth.
- Records piano key presses into an N-step note memory and plays them back at a selectable tempo.
- Arbitrates the single tone generator (oscillator/PWM path) between live keys and sequencer playback.
- Drives mode, beat LED and sequencer-on indicators; sits between the GPIO inputs and the oscillator inside sass_synth.

---
 rtl/sass_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sass_seq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sass_seq_ctrl.sv
// rtl/sass_seq_ctrl.sv - SaSS step sequencer, recorder and live/playback note arbiter.
// Optional SEQ_CLEAR_EN: note memory is cleared on every entry into OFF.
module sass_seq_ctrl #(
  parameter int NUM_STEPS  = 8,
  parameter int NUM_KEYS   = 15,
  parameter int TICKS_SLOW = 5000000,
  parameter int TICKS_FAST = 2500000
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 ncs,
  input  logic [NUM_KEYS-1:0]  piano_keys,
  input  logic                 seq_power,
  input  logic                 tempo_select,
  input  logic                 seq_play,
  output logic [3:0]           note_sel,
  output logic                 note_valid,
  output logic [1:0]           mode_out,
  output logic [NUM_STEPS-1:0] beat_led,
  output logic                 seq_led_on
);

  localparam int PW   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int TMAX = (TICKS_SLOW > TICKS_FAST) ? TICKS_SLOW : TICKS_FAST;
  localparam int CW   = $clog2(TMAX) + 1;
  localparam logic [CW-1:0]        TERM_SLOW = CW'(TICKS_SLOW - 1);
  localparam logic [CW-1:0]        TERM_FAST = CW'(TICKS_FAST - 1);
  localparam logic [NUM_STEPS-1:0] STEP0     = NUM_STEPS'(1);

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_REC  = 2'b01,
    S_PLAY = 2'b10
  } state_t;

  state_t               state, state_d;
  logic [PW-1:0]        rec_ptr, rec_ptr_d;
  logic [PW-1:0]        play_ptr, play_ptr_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [NUM_KEYS-1:0]  keys_q;
  logic                 play_q;
  logic [3:0]           mem [NUM_STEPS];

  logic [NUM_KEYS-1:0]  key_rise;
  logic                 play_rise;
  logic [3:0]           live_code, rise_code, play_note;
  logic                 tick;
  logic                 mem_we, mem_clr;
  logic [3:0]           note_sel_d;
  logic                 note_valid_d;
  logic [NUM_STEPS-1:0] beat_led_d;
  logic                 seq_led_on_d;

  // Lowest-index set bit k maps to note code k+1; no bit set maps to silence.
  function automatic logic [3:0] lowest_code(input logic [NUM_KEYS-1:0] v);
    logic [3:0] code;
    code = 4'd0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (v[k]) code = 4'(k + 1);
    return code;
  endfunction

  assign key_rise  = piano_keys & ~keys_q;
  assign play_rise = seq_play & ~play_q;
  assign live_code = lowest_code(piano_keys);
  assign rise_code = lowest_code(key_rise);
  assign tick      = cnt >= (tempo_select ? TERM_FAST : TERM_SLOW);
  assign mode_out  = state;

  always_comb begin
    state_d      = state;
    rec_ptr_d    = rec_ptr;
    play_ptr_d   = play_ptr;
    cnt_d        = cnt;
    mem_we       = 1'b0;
    mem_clr      = 1'b0;
    note_sel_d   = note_sel;
    note_valid_d = 1'b0;
    beat_led_d   = beat_led;
    seq_led_on_d = seq_led_on;
    play_note    = 4'd0;

    case (state)
      S_OFF: begin
        rec_ptr_d  = '0;
        play_ptr_d = '0;
        cnt_d      = '0;
        if (seq_power) state_d = S_REC;
      end
      S_REC: begin
        if (key_rise != '0) begin
          mem_we    = 1'b1;
          rec_ptr_d = rec_ptr + 1'b1;
        end
        if (play_rise) begin
          state_d    = S_PLAY;
          play_ptr_d = '0;
          cnt_d      = '0;
        end
      end
      S_PLAY: begin
        // A toggle back to RECORD swallows a coincident tempo tick.
        if (play_rise) begin
          state_d = S_REC;
        end else if (tick) begin
          cnt_d      = '0;
          play_ptr_d = play_ptr + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase

    if (!seq_power) begin
      state_d    = S_OFF;
      rec_ptr_d  = '0;
      play_ptr_d = '0;
      cnt_d      = '0;
      mem_we     = 1'b0;
`ifdef SEQ_CLEAR_EN
      mem_clr    = (state != S_OFF);
`else
      mem_clr    = 1'b0;
`endif
    end

    if (ncs) begin
      state_d    = state;
      rec_ptr_d  = rec_ptr;
      play_ptr_d = play_ptr;
      cnt_d      = cnt;
      mem_we     = 1'b0;
      mem_clr    = 1'b0;
    end else begin
      // Bypass so a step written on the RECORD->PLAY edge is heard immediately.
      play_note = (mem_we && (rec_ptr == play_ptr_d)) ? rise_code : mem[play_ptr_d];
      case (state_d)
        S_REC: begin
          note_sel_d   = live_code;
          beat_led_d   = STEP0 << rec_ptr_d;
          seq_led_on_d = 1'b0;
        end
        S_PLAY: begin
          note_sel_d   = (live_code != 4'd0) ? live_code : play_note;
          beat_led_d   = STEP0 << play_ptr_d;
          seq_led_on_d = 1'b1;
        end
        default: begin
          note_sel_d   = live_code;
          beat_led_d   = '0;
          seq_led_on_d = 1'b0;
        end
      endcase
      note_valid_d = (note_sel_d != 4'd0);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_OFF;
      rec_ptr    <= '0;
      play_ptr   <= '0;
      cnt        <= '0;
      keys_q     <= '0;
      play_q     <= 1'b0;
      note_sel   <= 4'd0;
      note_valid <= 1'b0;
      beat_led   <= '0;
      seq_led_on <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) mem[i] <= 4'd0;
    end else begin
      state      <= state_d;
      rec_ptr    <= rec_ptr_d;
      play_ptr   <= play_ptr_d;
      cnt        <= cnt_d;
      note_sel   <= note_sel_d;
      note_valid <= note_valid_d;
      beat_led   <= beat_led_d;
      seq_led_on <= seq_led_on_d;
      if (!ncs) begin
        keys_q <= piano_keys;
        play_q <= seq_play;
      end
      if (mem_clr) begin
        for (int i = 0; i < NUM_STEPS; i++) mem[i] <= 4'd0;
      end else if (mem_we) begin
        mem[rec_ptr] <= rise_code;
      end
    end
  end

endmodule

// File: tb/tb_sass_seq_ctrl.sv
// tb/tb_sass_seq_ctrl.sv - directed self-checking bench for sass_seq_ctrl (TICKS_SLOW=8, TICKS_FAST=4).
module tb_sass_seq_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        ncs = 1'b0;
  logic [14:0] piano_keys = '0;
  logic        seq_power = 1'b0;
  logic        tempo_select = 1'b0;
  logic        seq_play = 1'b0;
  logic [3:0]  note_sel;
  logic        note_valid;
  logic [1:0]  mode_out;
  logic [7:0]  beat_led;
  logic        seq_led_on;

  int passed = 0;
  int total  = 0;

  sass_seq_ctrl #(
    .NUM_STEPS(8),
    .NUM_KEYS(15),
    .TICKS_SLOW(8),
    .TICKS_FAST(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .ncs(ncs),
    .piano_keys(piano_keys),
    .seq_power(seq_power),
    .tempo_select(tempo_select),
    .seq_play(seq_play),
    .note_sel(note_sel),
    .note_valid(note_valid),
    .mode_out(mode_out),
    .beat_led(beat_led),
    .seq_led_on(seq_led_on)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick(2);
    total++; if (note_sel !== 4'd0) $display("FAIL reset_note: got %0d expected 0", note_sel); else passed++;
    total++; if (note_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", note_valid); else passed++;
    total++; if (mode_out !== 2'b00) $display("FAIL reset_mode: got %b expected 00", mode_out); else passed++;
    total++; if (beat_led !== 8'h00) $display("FAIL reset_beat: got %b expected 00000000", beat_led); else passed++;
    total++; if (seq_led_on !== 1'b0) $display("FAIL reset_seqled: got %0b expected 0", seq_led_on); else passed++;
    n_rst = 1'b1;
    tick(1);
  endtask

  task automatic test_live_keys();
    piano_keys = 15'd1 << 4;
    total++; if (note_sel !== 4'd0) $display("FAIL live_latency: got %0d expected 0", note_sel); else passed++;
    tick(1);
    total++; if (note_sel !== 4'd5) $display("FAIL live_note: got %0d expected 5", note_sel); else passed++;
    total++; if (note_valid !== 1'b1) $display("FAIL live_valid: got %0b expected 1", note_valid); else passed++;
    total++; if (mode_out !== 2'b00) $display("FAIL live_mode: got %b expected 00", mode_out); else passed++;
    total++; if (beat_led !== 8'h00) $display("FAIL live_beat: got %b expected 0", beat_led); else passed++;
    piano_keys = (15'd1 << 3) | (15'd1 << 7);
    tick(1);
    total++; if (note_sel !== 4'd4) $display("FAIL live_lowest: got %0d expected 4", note_sel); else passed++;
    piano_keys = '0;
    tick(1);
    total++; if (note_valid !== 1'b0) $display("FAIL live_release: got %0b expected 0", note_valid); else passed++;
  endtask

  task automatic test_record();
    seq_power = 1'b1;
    tick(1);
    total++; if (mode_out !== 2'b01) $display("FAIL rec_mode: got %b expected 01", mode_out); else passed++;
    total++; if (beat_led !== 8'h01) $display("FAIL rec_beat0: got %b expected 00000001", beat_led); else passed++;
    piano_keys = 15'd1;      tick(1);
    total++; if (beat_led !== 8'h02) $display("FAIL rec_beat1: got %b expected 00000010", beat_led); else passed++;
    piano_keys = '0;         tick(1);
    piano_keys = 15'd1 << 2; tick(1);
    total++; if (note_sel !== 4'd3) $display("FAIL rec_live: got %0d expected 3", note_sel); else passed++;
    piano_keys = '0;         tick(1);
    piano_keys = 15'd1 << 4; tick(1);
    piano_keys = '0;         tick(1);
    total++; if (beat_led !== 8'b00001000) $display("FAIL rec_beat3: got %b expected 00001000", beat_led); else passed++;
  endtask

  task automatic test_playback();
    seq_play = 1'b1;
    tick(1);
    seq_play = 1'b0;
    total++; if (mode_out !== 2'b10) $display("FAIL play_mode: got %b expected 10", mode_out); else passed++;
    total++; if (seq_led_on !== 1'b1) $display("FAIL play_seqled: got %0b expected 1", seq_led_on); else passed++;
    total++; if (note_sel !== 4'd1) $display("FAIL play_step0: got %0d expected 1", note_sel); else passed++;
    tick(7);
    total++; if (note_sel !== 4'd1) $display("FAIL play_step0_hold: got %0d expected 1", note_sel); else passed++;
    tick(1);
    total++; if (note_sel !== 4'd3) $display("FAIL play_step1: got %0d expected 3", note_sel); else passed++;
    total++; if (beat_led !== 8'h02) $display("FAIL play_beat1: got %b expected 00000010", beat_led); else passed++;
    tick(8);
    total++; if (note_sel !== 4'd5) $display("FAIL play_step2: got %0d expected 5", note_sel); else passed++;
    tick(8);
    total++; if (note_sel !== 4'd0 || note_valid !== 1'b0)
      $display("FAIL play_step3: got note %0d valid %0b expected 0/0", note_sel, note_valid); else passed++;
    tick(32);
    total++; if (beat_led !== 8'h80) $display("FAIL play_step7: got %b expected 10000000", beat_led); else passed++;
    tick(8);
    total++; if (note_sel !== 4'd1 || beat_led !== 8'h01)
      $display("FAIL play_wrap: got note %0d beat %b expected 1/00000001", note_sel, beat_led); else passed++;
  endtask

  task automatic test_tempo_switch();
    tick(6);
    total++; if (note_sel !== 4'd1) $display("FAIL tempo_before: got %0d expected 1", note_sel); else passed++;
    tempo_select = 1'b1;
    tick(1);
    total++; if (note_sel !== 4'd3) $display("FAIL tempo_immediate: got %0d expected 3", note_sel); else passed++;
    tick(3);
    total++; if (note_sel !== 4'd3) $display("FAIL tempo_fast_hold: got %0d expected 3", note_sel); else passed++;
    tick(1);
    total++; if (note_sel !== 4'd5) $display("FAIL tempo_fast_step: got %0d expected 5", note_sel); else passed++;
  endtask

  task automatic test_live_override();
    piano_keys = 15'd1 << 9;
    tick(1);
    total++; if (note_sel !== 4'd10) $display("FAIL override_live: got %0d expected 10", note_sel); else passed++;
    tick(1);
    piano_keys = '0;
    tick(1);
    total++; if (note_sel !== 4'd5) $display("FAIL override_release: got %0d expected 5", note_sel); else passed++;
  endtask

  task automatic test_chip_select();
    ncs = 1'b1;
    tick(1);
    total++; if (note_valid !== 1'b0) $display("FAIL ncs_valid: got %0b expected 0", note_valid); else passed++;
    piano_keys = 15'd1 << 1;
    tick(17);
    piano_keys = '0;
    tick(2);
    total++; if (note_sel !== 4'd5) $display("FAIL ncs_note_hold: got %0d expected 5", note_sel); else passed++;
    total++; if (beat_led !== 8'h04 || mode_out !== 2'b10)
      $display("FAIL ncs_state_hold: got beat %b mode %b expected 00000100/10", beat_led, mode_out); else passed++;
    ncs = 1'b0;
    tick(1);
    total++; if (beat_led !== 8'h08) $display("FAIL ncs_counter_frozen: got %b expected 00001000", beat_led); else passed++;
  endtask

  task automatic test_record_play_same_cycle();
    seq_play = 1'b1; tick(1);
    seq_play = 1'b0;
    total++; if (mode_out !== 2'b01 || beat_led !== 8'h08)
      $display("FAIL back_to_rec: got mode %b beat %b expected 01/00001000", mode_out, beat_led); else passed++;
    tick(1);
    piano_keys = 15'd1 << 6;
    seq_play = 1'b1;
    tick(1);
    total++; if (mode_out !== 2'b10 || note_sel !== 4'd7)
      $display("FAIL same_cycle_play: got mode %b note %0d expected 10/7", mode_out, note_sel); else passed++;
    piano_keys = '0;
    seq_play = 1'b0;
    tick(1);
    total++; if (note_sel !== 4'd1) $display("FAIL same_cycle_step0: got %0d expected 1", note_sel); else passed++;
    tick(11);
    total++; if (note_sel !== 4'd7 || beat_led !== 8'h08)
      $display("FAIL same_cycle_written: got note %0d beat %b expected 7/00001000", note_sel, beat_led); else passed++;
    seq_play = 1'b1; tick(1);
    seq_play = 1'b0;
    total++; if (beat_led !== 8'h10) $display("FAIL same_cycle_recptr: got %b expected 00010000", beat_led); else passed++;
    tick(1);
  endtask

  task automatic test_power_off_memory();
    logic [3:0] exp_note;
`ifdef SEQ_CLEAR_EN
    exp_note = 4'd0;
`else
    exp_note = 4'd1;
`endif
    seq_power = 1'b0;
    tick(1);
    total++; if (mode_out !== 2'b00 || beat_led !== 8'h00 || seq_led_on !== 1'b0)
      $display("FAIL off_outputs: got mode %b beat %b led %0b expected 00/0/0", mode_out, beat_led, seq_led_on); else passed++;
    seq_power = 1'b1;
    tick(1);
    total++; if (beat_led !== 8'h01) $display("FAIL off_recptr_reset: got %b expected 00000001", beat_led); else passed++;
    seq_play = 1'b1; tick(1);
    seq_play = 1'b0;
    total++; if (note_sel !== exp_note) $display("FAIL off_memory: got %0d expected %0d", note_sel, exp_note); else passed++;
  endtask

  task automatic test_async_reset();
    #3 n_rst = 1'b0;
    #1;
    total++; if (note_sel !== 4'd0 || note_valid !== 1'b0 || mode_out !== 2'b00 || beat_led !== 8'h00 || seq_led_on !== 1'b0)
      $display("FAIL async_reset: got note %0d valid %0b mode %b beat %b led %0b expected all 0",
               note_sel, note_valid, mode_out, beat_led, seq_led_on); else passed++;
    #1 n_rst = 1'b1;
    tick(1);
    seq_play = 1'b1; tick(1);
    seq_play = 1'b0;
    total++; if (mode_out !== 2'b10 || note_sel !== 4'd0 || note_valid !== 1'b0)
      $display("FAIL reset_clears_mem: got mode %b note %0d valid %0b expected 10/0/0", mode_out, note_sel, note_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_live_keys();
    test_record();
    test_playback();
    test_tempo_switch();
    test_live_override();
    test_chip_select();
    test_record_play_same_cycle();
    test_power_off_memory();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
